// File: rtl/dp_ctrl_pkg.sv
// Shared constants for the datapath run controller: FSM state codes and opcode field decoding.
package dp_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_READY = 3'd2;
    localparam state_t ST_CLR   = 3'd3;
    localparam state_t ST_RUN   = 3'd4;
    localparam state_t ST_DONE  = 3'd5;
    localparam state_t ST_TOUT  = 3'd6;

    localparam logic [4:0] OPC_HLT = 5'b11111;
    localparam logic [4:0] OPC_OUT = 5'b11100;
    localparam logic [4:0] OPC_LDR = 5'b00011;
    localparam logic [4:0] OPC_LLI = 5'b00001;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/dp_out_fifo.sv
// Result FIFO: power-of-2 depth, registered pointers, head word visible combinationally.
// Latency: a push is visible on pop_dat/empty the cycle after the push edge.
// Backpressure: push into a full FIFO without a pop is dropped and sets sticky overflow.
module dp_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!clr_n || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dp_run_ctrl.sv
// Run controller: loads program image via ext_* ports, clears and runs the datapath, halts on HLT/watchdog.
// Latency: ext write one cycle after beat accept; OutR captured into the FIFO one cycle after its register write.
// Backpressure: load_ready only in LOAD; full result FIFO drops captures (sticky out_overflow). RUN_STEP_EN adds single-step.
module dp_run_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         MAX_CYCLES = 1024,
    parameter int         CLR_CYCLES = 2,
    parameter logic [4:0] HLT_OPCODE = OPC_HLT
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        load_sel,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    input  logic        load_last,
    input  logic        start,
`ifdef RUN_STEP_EN
    input  logic        step,
    input  logic        step_mode,
`endif
    output logic        test_normal,
    output logic        ext_instr_we,
    output logic [15:0] ext_instr_addr,
    output logic [15:0] ext_instr_data,
    output logic        ext_data_write_en,
    output logic [15:0] ext_data_addr,
    output logic [15:0] ext_data_data,
    output logic        dp_clr,
    output logic        flag_HLT,
    input  logic [15:0] mem_instr_out,
    input  logic        flag_OutR,
    input  logic [15:0] OutR,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        out_overflow,
    output logic [15:0] cycle_count
);

    localparam logic [7:0]  CLR_LAST = 8'(CLR_CYCLES - 1);
    localparam logic [15:0] MAX_LAST = 16'(MAX_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] clr_cnt;
    logic       run;
    logic       adv;
    logic       hlt_hit;
    logic       idle_like;
    logic       accept;
    logic       enter_clr;
    logic       out_pend;
    logic       fifo_empty;

    assign run = (state == ST_RUN);

`ifdef RUN_STEP_EN
    assign adv = run && (!step_mode || step);
`else
    assign adv = run;
`endif

    assign hlt_hit     = (opcode_of(mem_instr_out) == HLT_OPCODE);
    assign flag_HLT    = adv && !hlt_hit;
    assign load_ready  = (state == ST_LOAD);
    assign accept      = load_valid && load_ready;
    assign idle_like   = (state == ST_IDLE) || (state == ST_READY) ||
                         (state == ST_DONE) || (state == ST_TOUT);
    assign enter_clr   = idle_like && !load_valid && start;
    assign test_normal = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_READY);
    assign dp_clr      = (state == ST_CLR);
    assign busy        = (state == ST_LOAD) || (state == ST_CLR) || run;
    assign done        = (state == ST_DONE);
    assign timeout     = (state == ST_TOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (accept && load_last) state_nxt = ST_READY;
            ST_CLR:  if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
            ST_RUN: begin
                if (adv && hlt_hit)                    state_nxt = ST_DONE;
                else if (adv && cycle_count == MAX_LAST) state_nxt = ST_TOUT;
            end
            default: begin
                if (load_valid) state_nxt = ST_LOAD;
                else if (start) state_nxt = ST_CLR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state             <= ST_IDLE;
            clr_cnt           <= '0;
            cycle_count       <= '0;
            out_pend          <= 1'b0;
            ext_instr_we      <= 1'b0;
            ext_instr_addr    <= '0;
            ext_instr_data    <= '0;
            ext_data_write_en <= 1'b0;
            ext_data_addr     <= '0;
            ext_data_data     <= '0;
        end else begin
            state             <= state_nxt;
            ext_instr_we      <= accept && !load_sel;
            ext_data_write_en <= accept && load_sel;
            if (accept && !load_sel) begin
                ext_instr_addr <= load_addr;
                ext_instr_data <= load_data;
            end
            if (accept && load_sel) begin
                ext_data_addr <= load_addr;
                ext_data_data <= load_data;
            end
            // OutR is written at the edge that samples flag_OutR; push it one edge later.
            out_pend <= run && flag_OutR;
            if (enter_clr) begin
                clr_cnt     <= '0;
                cycle_count <= '0;
            end else begin
                if (dp_clr) clr_cnt <= clr_cnt + 8'd1;
                if (adv && cycle_count != 16'hFFFF) cycle_count <= cycle_count + 16'd1;
            end
        end
    end

    dp_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_out_fifo (
        .clk      (clk),
        .clr_n    (clr_n),
        .flush    (enter_clr),
        .push     (out_pend),
        .push_dat (OutR),
        .pop      (out_ready),
        .pop_dat  (out_data),
        .empty    (fifo_empty),
        .overflow (out_overflow)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_dp_run_ctrl.sv
// Bench for dp_run_ctrl with a small behavioural datapath/decoder model and scoreboarded outputs.
module tb_dp_run_ctrl;
    import dp_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        load_valid, load_ready, load_sel, load_last, start;
    logic [15:0] load_addr, load_data;
    logic        test_normal, ext_instr_we, ext_data_write_en, dp_clr, flag_HLT;
    logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
    logic [15:0] mem_instr_out, OutR, out_data, cycle_count;
    logic        flag_OutR, out_valid, out_ready, busy, done, timeout, out_overflow;
`ifdef RUN_STEP_EN
    logic        step, step_mode;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        sel;
        logic [15:0] addr;
        logic [15:0] dat;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    dp_run_ctrl #(.FIFO_DEPTH(4), .MAX_CYCLES(16), .CLR_CYCLES(2)) dut (
        .clk(clk), .clr_n(clr_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .start(start),
`ifdef RUN_STEP_EN
        .step(step), .step_mode(step_mode),
`endif
        .test_normal(test_normal),
        .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
        .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
        .dp_clr(dp_clr), .flag_HLT(flag_HLT),
        .mem_instr_out(mem_instr_out), .flag_OutR(flag_OutR), .OutR(OutR),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout(timeout),
        .out_overflow(out_overflow), .cycle_count(cycle_count)
    );

    // Behavioural datapath: LDR rd<=dmem[imm8], LLI rd<=imm8, OUT OutR<=rd, anything else is a no-op.
    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [15:0] regs [8];
    logic [15:0] pc;
    logic [15:0] outr_q;
    int          adv_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = 16'h0000;
        end
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        pc     = 16'h0000;
        outr_q = 16'h0000;
    end

    assign mem_instr_out = imem[pc[7:0]];
    assign flag_OutR     = flag_HLT && (mem_instr_out[15:11] == OPC_OUT);
    assign OutR          = outr_q;

    always @(posedge clk) begin
        if (ext_instr_we)      imem[ext_instr_addr[7:0]] <= ext_instr_data;
        if (ext_data_write_en) dmem[ext_data_addr[7:0]]  <= ext_data_data;
        if (dp_clr) begin
            pc     <= 16'h0000;
            outr_q <= 16'h0000;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (flag_HLT) begin
            case (mem_instr_out[15:11])
                OPC_LDR: regs[mem_instr_out[10:8]] <= dmem[mem_instr_out[7:0]];
                OPC_LLI: regs[mem_instr_out[10:8]] <= {8'h00, mem_instr_out[7:0]};
                OPC_OUT: outr_q <= regs[mem_instr_out[10:8]];
                default: ;
            endcase
            pc      <= pc + 16'd1;
            adv_cnt <= adv_cnt + 1;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Write-port monitor
    always @(negedge clk) begin
        if (ext_instr_we || ext_data_write_en) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: instr_we=%0b data_we=%0b with no expected write", ext_instr_we, ext_data_write_en);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_sel", {ext_instr_we, ext_data_write_en}, e.sel ? 32'h1 : 32'h2);
                chk("wr_addr", e.sel ? ext_data_addr : ext_instr_addr, e.addr);
                chk("wr_data", e.sel ? ext_data_data : ext_instr_data, e.dat);
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %0h with nothing expected", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic load_beat(input logic sel, input logic [15:0] a, input logic [15:0] d, input logic last);
        int n;
        n = 0;
        load_valid = 1'b1; load_sel = sel; load_addr = a; load_data = d; load_last = last;
        wr_q.push_back({sel, a, d});
        while (!load_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) begin
            total++;
            bad++;
            $display("FAIL load_accept: load_ready=0 want 1");
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_prog(output int clr_seen, output int run_seen, output int hlt_seen);
        int n;
        clr_seen = 0; run_seen = 0; hlt_seen = 0; n = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(done || timeout) && n < 100) begin
            if (dp_clr) clr_seen++;
            if (busy && !dp_clr && !test_normal) begin
                run_seen++;
                if (mem_instr_out[15:11] == OPC_HLT && !flag_HLT) hlt_seen++;
            end
            @(negedge clk);
            n++;
        end
    endtask

    logic [15:0] prog_out [13];
    int          c_clr, c_run, c_hlt;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
        load_last = 1'b0; start = 1'b0; out_ready = 1'b1;
`ifdef RUN_STEP_EN
        step = 1'b0; step_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_test_normal", test_normal, 1);
        chk("rst_flag_HLT", flag_HLT, 0);
        chk("rst_dp_clr", dp_clr, 0);
        chk("rst_we", {ext_instr_we, ext_data_write_en}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_overflow", out_overflow, 0);
        clr_n = 1'b1;
        @(negedge clk);

        // Image load: LDR R0,[0]; OUT R0; HLT; dmem[0]=1234
        load_beat(1'b0, 16'd0, 16'h1800, 1'b0);
        load_beat(1'b0, 16'd1, 16'hE020, 1'b0);
        load_beat(1'b0, 16'd2, 16'hF800, 1'b0);
        load_beat(1'b1, 16'd0, 16'h1234, 1'b1);
        chk("ready_busy", busy, 0);
        chk("ready_test_normal", test_normal, 1);
        chk("ready_load_ready", load_ready, 0);
        @(negedge clk);
        chk("load_wr_drained", wr_q.size(), 0);

        // LDR/OUT/HLT run
        exp_q.push_back(16'h1234);
        run_prog(c_clr, c_run, c_hlt);
        chk("t2_clr_cycles", c_clr, 2);
        chk("t2_run_cycles", c_run, 3);
        chk("t2_hlt_low", c_hlt, 1);
        chk("t2_done", done, 1);
        chk("t2_cycle_count", cycle_count, 3);
        chk("t2_flag_HLT", flag_HLT, 0);
        chk("t2_test_normal", test_normal, 0);
        chk("t2_out_valid", out_valid, 1);
        @(negedge clk);
        chk("t2_drained", exp_q.size(), 0);

        // Runaway program: watchdog after 16 RUN cycles
        load_beat(1'b0, 16'd0, 16'h0000, 1'b0);
        load_beat(1'b0, 16'd1, 16'h0000, 1'b0);
        load_beat(1'b0, 16'd2, 16'h0000, 1'b1);
        run_prog(c_clr, c_run, c_hlt);
        chk("t3_run_cycles", c_run, 16);
        chk("t3_timeout", timeout, 1);
        chk("t3_done", done, 0);
        chk("t3_cycle_count", cycle_count, 16);
        chk("t3_flag_HLT", flag_HLT, 0);
        @(negedge clk);
        chk("t3_flag_HLT_later", flag_HLT, 0);
        chk("t3_timeout_held", timeout, 1);

        // Six OUTs into a 4-deep FIFO with no draining
        for (int i = 0; i < 6; i++) begin
            prog_out[2*i]   = 16'h0800 | 16'(8'h11 * (i + 1));
            prog_out[2*i+1] = 16'hE000;
        end
        prog_out[12] = 16'hF800;
        for (int i = 0; i < 13; i++) load_beat(1'b0, 16'(i), prog_out[i], i == 12);
        out_ready = 1'b0;
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        exp_q.push_back(16'h0033);
        exp_q.push_back(16'h0044);
        run_prog(c_clr, c_run, c_hlt);
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_cycle_count", cycle_count, 13);
        chk("t4_overflow", out_overflow, 1);
        chk("t4_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t4_empty", out_valid, 0);
        chk("t4_overflow_sticky", out_overflow, 1);
        chk("t4_drained", exp_q.size(), 0);

        // Reset in the middle of a run
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c_run = 0;
        for (int n = 0; n < 40 && c_run < 5; n++) begin
            if (busy && !dp_clr && !test_normal) c_run++;
            @(negedge clk);
        end
        chk("t5_running", busy && !test_normal, 1);
        chk("t5_pre_valid", out_valid, 1);
        clr_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_flag_HLT", flag_HLT, 0);
        chk("t5_test_normal", test_normal, 1);
        chk("t5_cycle_count", cycle_count, 0);
        chk("t5_dp_clr", dp_clr, 0);
        clr_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

`ifdef RUN_STEP_EN
        begin
            int adv0;
            load_beat(1'b0, 16'd0, 16'h0000, 1'b0);
            load_beat(1'b0, 16'd1, 16'h0000, 1'b0);
            load_beat(1'b0, 16'd2, 16'h0000, 1'b0);
            load_beat(1'b0, 16'd3, 16'hF800, 1'b1);
            step_mode = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int n = 0; n < 20 && (dp_clr || !busy); n++) @(negedge clk);
            adv0 = adv_cnt;
            for (int k = 0; k < 3; k++) begin
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
                repeat (2) @(negedge clk);
            end
            chk("step_advances", adv_cnt - adv0, 3);
            chk("step_cycle_count", cycle_count, 3);
            chk("step_still_run", busy, 1);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            chk("step_done", done, 1);
            chk("step_adv_final", adv_cnt - adv0, 3);
            step_mode = 1'b0;
        end
`endif

        chk("final_wr_q", wr_q.size(), 0);
        chk("final_exp_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_run_ctrl.md
Name: dp_run_ctrl

Overview:
- Run controller for Datapath_Module.
- Loads a program image into the datapath's instruction and data memories through the ext_* test ports, then pulses the datapath clear and enables execution.
- Detects the HLT opcode and stops execution; a watchdog counter also stops runaway programs.
- Buffers every OutR write in a small FIFO so that a host or bench can drain the results with a valid/ready handshake.
- Per-instruction decode (ALU, RF and PC selects, flag_OutR) comes from the decoder. This block only sequences the datapath.

Parameters:
- FIFO_DEPTH, 4: OutR result FIFO entries; must be a power of 2, ≥2.
- MAX_CYCLES, 1024: watchdog limit, in RUN cycles.
- CLR_CYCLES, 2: number of cycles dp_clr is held high.
- HLT_OPCODE, 5'b11111: value of mem_instr_out[15:11] that halts the program.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr_n  in  1  synchronous active-low reset.
- load_valid  in  1  load beat valid.
- load_ready  out  1  load beat accepted when valid&ready.
- load_sel  in  1  0 = instruction memory, 1 = data memory.
- load_addr  in  16  target address.
- load_data  in  16  target word.
- load_last  in  1  marks the final beat of the image.
- start  in  1  one-cycle pulse; begins execution.
- test_normal  out  1  to datapath; 1 = external access mode.
- ext_instr_we  out  1  to datapath.
- ext_instr_addr  out  16  to datapath.
- ext_instr_data  out  16  to datapath.
- ext_data_write_en  out  1  to datapath.
- ext_data_addr  out  16  to datapath.
- ext_data_data  out  16  to datapath.
- dp_clr  out  1  to datapath clr (active-high).
- flag_HLT  out  1  to datapath; 1 = PC/state advance enabled.
- mem_instr_out  in  16  current instruction from datapath.
- flag_OutR  in  1  from decoder; OutR is written this cycle.
- OutR  in  16  from datapath.
- out_valid  out  1  FIFO not empty.
- out_data  out  16  FIFO head.
- out_ready  in  1  pop when out_valid&out_ready.
- busy  out  1  state is LOAD, CLR or RUN.
- done  out  1  state is DONE.
- timeout  out  1  state is TOUT.
- out_overflow  out  1  sticky; a capture was dropped.
- cycle_count  out  16  RUN cycles of the last or current run.

Behaviour:
- Reset (clr_n=0 at an edge):
  - state becomes IDLE; the FIFO is emptied; cycle_count=0; out_overflow=0.
  - All write enables are 0; dp_clr=0; flag_HLT=0; test_normal=1.
  - Reset applies in any state and aborts load or run immediately.
- States: IDLE, LOAD, READY, CLR, RUN, DONE, TOUT.
- Transitions:
  - IDLE/READY/DONE/TOUT → LOAD: on load_valid.
  - IDLE/READY/DONE/TOUT → CLR: on start. If load_valid and start arrive together, load wins.
  - LOAD → READY: after accepting a beat with load_last.
- LOAD state:
  - load_ready=1 only in LOAD; beats are accepted one per cycle.
  - An accepted beat registers addr/data into the selected ext_* bus.
  - The selected write enable pulses high for exactly the next cycle; there is one write per beat.
  - The final write pulse issues in the first READY cycle.
  - start is ignored while in LOAD.
- CLR state:
  - test_normal=0 and dp_clr=1 for CLR_CYCLES cycles, then → RUN.
  - On entering CLR: FIFO flushed, cycle_count=0, out_overflow=0.
- RUN state:
  - test_normal=0; cycle_count increments every cycle.
  - Halt: flag_HLT = (state==RUN) & (mem_instr_out[15:11]!=HLT_OPCODE), combinational, so the HLT instruction never advances the PC. The next edge goes → DONE.
  - Watchdog: cycle_count reaching MAX_CYCLES-1 → TOUT. If HLT occurs in the same cycle, HLT wins.
- Capture:
  - A flag_OutR sampled high in RUN sets out_pend.
  - The next edge pushes OutR (the value already updated) into the FIFO; latency is 1 cycle after the OutR register write.
  - A pending push still completes on the RUN→DONE or RUN→TOUT edge.
- FIFO:
  - Push when full with no pop: data dropped, out_overflow set.
  - Push and pop in the same cycle when full: both occur.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- DONE/TOUT: flag_HLT=0; test_normal=0 so OutR and memories stay readable. FIFO draining continues in all states.
- Widths: cycle_count is 16-bit and saturates at 16'hFFFF.

Optional Feature:
- Macro RUN_STEP_EN.
- Defined:
  - Adds input step (1 bit) and input step_mode (1 bit).
  - In RUN with step_mode=1, flag_HLT is high only in cycles where step=1, still gated by the HLT rule.
  - cycle_count and the watchdog advance only on those cycles.
- Undefined: no step or step_mode ports; RUN runs free.

Decomposition:
- Shared package dp_ctrl_pkg holds:
  - the state enum;
  - the opcode constants: OPC_HLT, OPC_OUT=5'b11100, OPC_LDR=5'b00011, OPC_LLI=5'b00001;
  - the opcode field slice 15:11.
- Sub-module dp_out_fifo (parameterised by depth and width, with push, pop, full, empty and overflow) is instantiated once.

Test Plan:
- Load beats (sel0,0,16'h1800), (sel0,1,16'hE020), (sel1,0,16'h1234,last) → ext_instr_we pulses at addr 0 then 1, ext_data_write_en pulses at addr 0 with 16'h1234; state is READY afterwards.
- start after the LDR/OUT program with the decoder attached, with 16'hF800 at addr 2 → dp_clr high 2 cycles; out_data=16'h1234 valid 1 cycle after the OUT write; flag_HLT low at HLT; done=1, cycle_count=3.
- Program with no HLT, MAX_CYCLES=16 → timeout=1 after 16 RUN cycles; flag_HLT=0 afterwards.
- Six OUT writes with out_ready=0, FIFO_DEPTH=4 → 4 entries kept, out_overflow=1; popping returns the first four values in order.
- clr_n=0 mid-RUN → next cycle state IDLE, FIFO empty, flag_HLT=0, test_normal=1.
- With RUN_STEP_EN, step_mode=1 and three step pulses → exactly three datapath advances, cycle_count=3.
